// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode holding register with load-use stall and redirect squash
// One-entry skid between fetch and EX; counts stall cycles and squashed instructions.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        ex_ready,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        redirect,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_hazard;
  logic        w_fire_in;
  logic        w_fire_out;

  assign w_opcode = r_instr[6:0];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];

  // R-type, store and branch read both sources; load, OP-IMM and JALR read rs1 only.
  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      7'b0000011, 7'b0010011, 7'b1100111: begin
        w_use_rs1 = 1'b1;
      end
      default: begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
      end
    endcase
  end

  assign w_hazard = r_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((w_use_rs1 && (w_rs1 == ex_rd)) || (w_use_rs2 && (w_rs2 == ex_rd)));

  assign id_valid   = r_valid && !w_hazard && !redirect;
  assign id_instr   = r_instr;
  assign id_pc      = r_pc;
  assign w_fire_out = id_valid && ex_ready;
  assign if_ready   = !redirect && (!r_valid || w_fire_out);
  assign w_fire_in  = if_valid && if_ready;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_instr     <= 32'h0;
      r_pc        <= 32'h0;
      r_stall_cnt <= 16'h0;
      r_flush_cnt <= 16'h0;
    end else begin
      if (w_hazard && !redirect && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (redirect && r_valid && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
      // if_ready is already low under redirect, so fire_in cannot win over the squash.
      if (redirect) begin
        r_valid <= 1'b0;
      end else if (w_fire_in) begin
        r_valid <= 1'b1;
        r_instr <= if_instr;
        r_pc    <= if_pc;
      end else if (w_fire_out) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against a behavioural model
// Driver models the pipeline register; a monitor checks every instruction EX accepts.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        ex_ready;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        redirect;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] sb[$];

  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  int          m_stall;
  int          m_flush;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .ex_ready(ex_ready), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .redirect(redirect),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [6:0] op;
    logic [4:0] s1;
    logic [4:0] s2;
    op = ins[6:0];
    s1 = ins[19:15];
    s2 = ins[24:20];
    if (op inside {7'b0110011, 7'b0100011, 7'b1100011}) return (s1 == r) || (s2 == r);
    if (op inside {7'b0000011, 7'b0010011, 7'b1100111}) return (s1 == r);
    return 1'b0;
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic er, input logic ld, input logic [4:0] rd,
                      input logic rdr, input logic r);
    bit haz, e_idv, e_ifr;
    @(negedge clk);
    if_valid = v; if_instr = ins; if_pc = pc;
    ex_ready = er; ex_is_load = ld; ex_rd = rd; redirect = rdr; rst = r;
    #1;
    haz   = m_valid && ld && (rd != 0) && reads_reg(m_instr, rd);
    e_idv = m_valid && !haz && !rdr;
    e_ifr = !rdr && (!m_valid || (e_idv && er));
    chk("if_ready", {31'b0, if_ready}, {31'b0, e_ifr});
    chk("id_valid", {31'b0, id_valid}, {31'b0, e_idv});
    chk("stall_cnt", {16'b0, stall_cnt}, m_stall);
    chk("flush_cnt", {16'b0, flush_cnt}, m_flush);
    if (m_valid) begin
      chk("id_instr", id_instr, m_instr);
      chk("id_pc", id_pc, m_pc);
    end
    if (!r) begin
      if (rdr && m_valid && sb.size() > 0) void'(sb.pop_back());
      if (v && e_ifr) sb.push_back({ins, pc});
    end
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_instr = 0; m_pc = 0; m_stall = 0; m_flush = 0;
      sb.delete();
    end else begin
      if (haz && !rdr && m_stall < 65535) m_stall++;
      if (rdr && m_valid && m_flush < 65535) m_flush++;
      if (rdr) m_valid = 0;
      else if (v && e_ifr) begin m_valid = 1; m_instr = ins; m_pc = pc; end
      else if (e_idv && er) m_valid = 0;
    end
  endtask

  // Monitor: every cycle EX takes the offer, it must be the oldest accepted fetch.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (id_valid && ex_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", id_instr, 32'hDEADBEEF);
        end else begin
          e = sb.pop_front();
          chk("sb_instr", id_instr, e[63:32]);
          chk("sb_pc", id_pc, e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[10];
    logic [31:0] w;
    ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011, 7'b0010011,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 9)];
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    logic [31:0] pc;
    m_valid = 0; m_instr = 0; m_pc = 0; m_stall = 0; m_flush = 0;
    rst = 1; if_valid = 0; if_instr = 0; if_pc = 0;
    ex_ready = 0; ex_is_load = 0; ex_rd = 0; redirect = 0;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // Back-to-back stream
    step(1, 32'h00500093, 32'h0, 1, 0, 0, 0, 0);
    for (int i = 1; i < 6; i++) step(1, 32'h00500093 + (i << 7), i * 4, 1, 0, 3, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    // Load-use stall on add x3,x1,x2 with load into x2
    step(1, 32'h002081B3, 32'h100, 1, 0, 0, 0, 0);
    step(1, 32'h00000013, 32'h104, 1, 1, 2, 0, 0);
    step(1, 32'h00000013, 32'h104, 1, 0, 2, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    // No hazard: lui, and add against x0
    step(1, 32'h123450B7, 32'h200, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0, 0);
    step(1, 32'h002081B3, 32'h204, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    // Redirect with held valid, then while empty
    step(1, 32'h002081B3, 32'h300, 0, 0, 0, 0, 0);
    step(1, 32'h00000013, 32'h304, 1, 0, 0, 1, 0);
    step(1, 32'h00000013, 32'h304, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk("flush_once", {16'b0, flush_cnt}, 32'd1);
    // EX backpressure
    step(1, 32'h00A00113, 32'h400, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h00B00193, 32'h404, 0, 0, 0, 0, 0);
    step(1, 32'h00B00193, 32'h404, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    // Randomized traffic
    pc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      logic v;
      v = ($urandom_range(0, 9) < 7);
      step(v, rand_instr(), pc, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
      pc = pc + 4;
    end
    // Persistent hazard to saturation, then reset mid-stall
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h002081B3, 32'h500, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(0, 0, 0, 1, 1, 2, 0, 0);
    chk("stall_saturated", {16'b0, stall_cnt}, 32'h0000FFFF);
    step(1, 32'h00000013, 32'h504, 1, 1, 2, 0, 1);
    step(0, 0, 0, 1, 1, 2, 0, 0);
    chk("stall_after_rst", {16'b0, stall_cnt}, 32'd0);
    chk("idv_after_rst", {31'b0, id_valid}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 if_valid  input  1  fetch stage presents an instruction.
REQ-005 if_instr  input  32  fetched instruction word.
REQ-006 if_pc  input  32  PC of if_instr.
REQ-007 if_ready  output  1  decode register can accept this cycle.
REQ-008 id_valid  output  1  held instruction offered to EX; feeds the immediate generator and decoder.
REQ-009 id_instr  output  32  held instruction word.
REQ-010 id_pc  output  32  held PC.
REQ-011 ex_ready  input  1  EX accepts the ID offer this cycle.
REQ-012 ex_is_load  input  1  instruction now in EX is a load (opcode 0000011).
REQ-013 ex_rd  input  5  destination register of the instruction in EX.
REQ-014 redirect  input  1  taken branch/jump resolved in EX; younger instructions are squashed.
REQ-015 stall_cnt  output  16  saturating count of load-use stall cycles.
REQ-016 flush_cnt  output  16  saturating count of squashed held instructions.

Function
REQ-017 State: held_valid flag, plus held instr/PC; states EMPTY (held_valid=0) and FULL (held_valid=1); STALL = FULL and hazard.
REQ-018 Source use by held opcode: 0110011, 0100011, 1100011 use rs1 (bits 19:15) and rs2 (bits 24:20); 0000011, 0010011, 1100111 use rs1 only; 0110111, 0010111, 1101111 and all other opcodes use none.
REQ-019 hazard = held_valid and ex_is_load and ex_rd != 0 and (used rs1 == ex_rd or used rs2 == ex_rd); combinational.
REQ-020 id_valid = held_valid and not hazard and not redirect; id_instr/id_pc always equal the held register contents.
REQ-021 fire_out = id_valid and ex_ready; fire_in = if_valid and if_ready.
REQ-022 if_ready = not redirect and (not held_valid or fire_out); combinational, no added latency.
REQ-023 Load on clock edge: fire_in -> held <= if_instr/if_pc, held_valid <= 1; else fire_out -> held_valid <= 0; else hold unchanged.
REQ-024 fire_in and fire_out in the same cycle SHALL replace the held instruction with zero bubble (one instruction per cycle throughput).
REQ-025 While STALL: held instruction and held_valid unchanged, if_ready=0, EX sees a bubble (id_valid=0) for that cycle.
REQ-026 redirect has priority over all other events: next cycle held_valid=0, incoming fetch not accepted (if_ready=0), id_valid=0 in the redirect cycle.
REQ-027 stall_cnt increments by 1 each cycle STALL is true and redirect=0; saturates at 0xFFFF.
REQ-028 flush_cnt increments by 1 each cycle redirect=1 and held_valid=1; saturates at 0xFFFF.
REQ-029 ex_rd = 0 SHALL never cause a hazard, regardless of ex_is_load.
REQ-030 Held contents while EMPTY are don't-care but SHALL not change id_valid (stays 0).

Reset
REQ-031 While rst=1 at a clock edge: held_valid=0, held instr=0x00000000, held PC=0x00000000, stall_cnt=0, flush_cnt=0; rst overrides redirect and fire_in.
REQ-032 After reset: id_valid=0, if_ready=1 (when redirect=0); reset asserted mid-stall drops the held instruction without counting.

Verification
REQ-033 Reset then if_valid=1, if_instr=0x00500093, if_pc=0x0, ex_ready=1 -> next cycle id_valid=1, id_instr=0x00500093; back-to-back stream sustains one per cycle.
REQ-034 Held 0x002081B3 (add x3,x1,x2), ex_is_load=1, ex_rd=2 -> id_valid=0, if_ready=0, stall_cnt 0->1; ex_is_load=0 next cycle -> id_valid=1.
REQ-035 Held 0x123450B7 (lui), ex_is_load=1, ex_rd=1 -> no hazard, id_valid=1, stall_cnt unchanged; same with held add and ex_rd=0 -> no hazard.
REQ-036 Held valid, if_valid=1, redirect=1 -> if_ready=0, id_valid=0; next cycle held_valid=0, flush_cnt=1; redirect while EMPTY -> flush_cnt unchanged.
REQ-037 Force persistent hazard 70000 cycles -> stall_cnt saturates at 0xFFFF; assert rst mid-stall -> all counters 0, id_valid=0 next cycle.
REQ-038 ex_ready=0 with held valid and if_valid=1 -> if_ready=0, held instruction stable, no loss or duplication when ex_ready returns to 1.
